// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: state encoding and default sizing.
package bit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_fa_bit.sv
// One-bit full-adder cell used as the single arithmetic element of the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Sequential add/subtract engine: operands shift LSB-first through one full-adder cell,
// one bit per clock, with a start/ready/done handshake and held result/flags.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  state_t state, next_state;

  logic [WIDTH-1:0] opa, opb, res_sr;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic             fa_s, fa_cout;
  logic             accept, last_bit;
  logic [WIDTH-1:0] final_res;

  fa_bit u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign ready     = (state == ST_IDLE) || (state == ST_DONE);
  assign busy      = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign accept    = start && ready;
  assign last_bit  = (count == CNT_W'(WIDTH - 1));
  assign final_res = {fa_s, res_sr[WIDTH-1:1]};

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_SHIFT;
      ST_SHIFT: if (last_bit) next_state = ST_DONE;
      ST_DONE:  next_state = accept ? ST_SHIFT : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // On the last bit the carry flop still holds the carry into the MSB,
  // so overflow is formed directly from it and the cell's carry-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      opa      <= '0;
      opb      <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
        count <= '0;
      end else if (state == ST_SHIFT) begin
        opa    <= opa >> 1;
        opb    <= opb >> 1;
        res_sr <= final_res;
        carry  <= fa_cout;
        if (last_bit) begin
          sum      <= final_res;
          cout     <= fa_cout;
          overflow <= carry ^ fa_cout;
          zero     <= (final_res == '0);
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             ready, busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout, overflow, zero;

  int checkCount = 0;
  int passCount  = 0;
  logic [WIDTH-1:0] lastSum;

  bit_serial_adder #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mcin,
                       input logic msub, output logic [7:0] es, output logic ec,
                       output logic eov, output logic ez);
    int full, sres;
    if (msub) begin
      full = int'(ma) + (255 - int'(mb)) + 1;
      sres = int'($signed(ma)) - int'($signed(mb));
    end else begin
      full = int'(ma) + int'(mb) + int'(mcin);
      sres = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
    end
    es  = full[7:0];
    ec  = full[8];
    eov = (sres > 127) || (sres < -128);
    ez  = (full[7:0] == 8'd0);
  endtask

  // Called at a negedge; the accept edge follows, returns at the next negedge.
  task automatic applyStimulus(input logic [7:0] sa, input logic [7:0] sb,
                               input logic scin, input logic ssub);
    checkOutput("ready_before_start", 32'(ready), 32'd1);
    a = sa; b = sb; cin = scin; sub = ssub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Waits for done (bounded), checking held results while busy, then the new result.
  task automatic finishOp(input logic [7:0] sa, input logic [7:0] sb, input logic scin,
                          input logic ssub, input bit jam);
    logic [7:0] es;
    logic ec, eov, ez;
    int n = 1;
    model(sa, sb, scin, ssub, es, ec, eov, ez);
    while (!done && n <= WIDTH + 4) begin
      checkOutput("sum_held_while_busy", 32'(sum), 32'(lastSum));
      if (jam && n >= 2 && n <= 5) begin
        start = 1'b1;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(n), 32'(WIDTH + 1));
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("sum", 32'(sum), 32'(es));
    checkOutput("cout", 32'(cout), 32'(ec));
    checkOutput("overflow", 32'(overflow), 32'(eov));
    checkOutput("zero", 32'(zero), 32'(ez));
    lastSum = es;
  endtask

  task automatic checkIdleAfter();
    @(negedge clk);
    checkOutput("done_single_pulse", 32'(done), 32'd0);
    checkOutput("ready_idle", 32'(ready), 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("sum_after_done", 32'(sum), 32'(lastSum));
  endtask

  initial begin
    int donePulses;
    logic [7:0] ra, rb;
    logic rc, rs;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lastSum = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_flags", {29'd0, cout, overflow, zero}, 32'd0);

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0); finishOp(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    checkOutput("dir_5a_3c", 32'(sum), 32'h96);
    checkIdleAfter();
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0); finishOp(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    checkIdleAfter();
    applyStimulus(8'h10, 8'h20, 1'b1, 1'b1); finishOp(8'h10, 8'h20, 1'b1, 1'b1, 0);
    checkIdleAfter();
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1); finishOp(8'h80, 8'h01, 1'b0, 1'b1, 0);
    checkOutput("dir_80_01_ovf", 32'(overflow), 32'd1);
    checkIdleAfter();

    // Start pulses while busy must be ignored.
    applyStimulus(8'h12, 8'h34, 1'b1, 1'b0); finishOp(8'h12, 8'h34, 1'b1, 1'b0, 1);
    checkIdleAfter();

    // Back-to-back: start held in the DONE cycle.
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0); finishOp(8'h33, 8'h44, 1'b0, 1'b0, 0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
    checkOutput("b2b_prior_held", 32'(sum), 32'h77);
    finishOp(8'h01, 8'h01, 1'b0, 1'b0, 0);
    checkOutput("b2b_sum", 32'(sum), 32'h02);
    checkIdleAfter();

    // Reset mid-operation aborts the shift without a done pulse.
    applyStimulus(8'hAB, 8'h11, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lastSum = '0;
    checkOutput("midrst_ready", 32'(ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_sum", 32'(sum), 32'd0);
    donePulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) donePulses++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 32'(donePulses), 32'd0);
    applyStimulus(8'hC8, 8'h64, 1'b0, 1'b1); finishOp(8'hC8, 8'h64, 1'b0, 1'b1, 0);
    checkIdleAfter();

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      applyStimulus(ra, rb, rc, rs);
      finishOp(ra, rb, rc, rs, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) checkIdleAfter();
      else @(negedge clk);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
